// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared constants and types for the iterative divider.
//   div_state_t : divider FSM states
//   DIV_WIDTH   : operand/result width the divider is built for
//   DIV_CYCLES  : number of BUSY iterations (one quotient bit per cycle)
//   DIV_CNT_W   : width of the iteration down-counter
package div_iter_pkg;

   localparam int DIV_WIDTH  = 32;
   localparam int DIV_CYCLES = DIV_WIDTH;
   localparam int DIV_CNT_W  = $clog2(DIV_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for DIV/DIVU (HI/LO path).
// Holds the pipeline via E_div_stall while a divide is in flight and drops
// it for the single DONE cycle in which quotient/remainder are valid.
//
// Ports:
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   div_req      E stage holds a valid DIV/DIVU
//   div_signed   1 = DIV (two's complement), 0 = DIVU
//   dividend     rs operand
//   divisor      rt operand
//   cancel       abort the E-stage instruction (beats div_req)
//   E_div_stall  freeze request to the hazard unit (combinational)
//   div_done     one-cycle pulse, result valid
//   quotient     result to LO (held until the next DONE)
//   remainder    result to HI (held until the next DONE)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for div_req; stall raised combinationally on accept
// BUSY  | one restoring step per cycle, counter runs DIV_CYCLES..1
// DONE  | sign-fixed results registered, div_done high, stall released
module div_iter
   import div_iter_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             div_req,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             cancel,
   output logic             E_div_stall,
   output logic             div_done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   div_state_t           state, state_nx;
   logic [DIV_CNT_W-1:0] cnt;
   logic [WIDTH-1:0]     rem_q, quo_q, dvsr_q;
   logic                 quo_neg, rem_neg;
   logic                 start, last;

   logic [WIDTH-1:0]     dvnd_mag, dvsr_mag;
   logic [WIDTH:0]       rem_sh, trial;
   logic [WIDTH-1:0]     rem_nx, quo_nx, quo_fix, rem_fix;

   assign dvnd_mag = (div_signed & dividend[WIDTH-1]) ? -dividend : dividend;
   assign dvsr_mag = (div_signed & divisor[WIDTH-1])  ? -divisor  : divisor;

   // rem < divisor holds between steps, so the WIDTH+1 bit difference never
   // overflows and trial[WIDTH] is a clean borrow/sign bit.
   assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
   assign trial   = rem_sh - {1'b0, dvsr_q};
   assign rem_nx  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quo_nx  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
   assign quo_fix = quo_neg ? -quo_nx : quo_nx;
   assign rem_fix = rem_neg ? -rem_nx : rem_nx;

   always_comb begin
      state_nx    = state;
      start       = resetn & (state == IDLE) & div_req & ~cancel;
      last        = (state == BUSY) & (cnt == DIV_CNT_W'(1));
      E_div_stall = start | (state == BUSY);
      case (state)
         IDLE:    if (start) state_nx = BUSY;
         BUSY:    if (last)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (cancel) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         cnt       <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         quo_neg   <= 1'b0;
         rem_neg   <= 1'b0;
         div_done  <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         state    <= state_nx;
         div_done <= 1'b0;
         if (start) begin
            rem_q   <= '0;
            quo_q   <= dvnd_mag;
            dvsr_q  <= dvsr_mag;
            // Zero divisor keeps the all-ones quotient unsigned; the remainder
            // sign fix then returns the dividend exactly as supplied.
            quo_neg <= div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]) & (|divisor);
            rem_neg <= div_signed & dividend[WIDTH-1];
            cnt     <= DIV_CNT_W'(DIV_CYCLES);
         end else if ((state == BUSY) && !cancel) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt   <= cnt - DIV_CNT_W'(1);
            // Final step lands straight in the result registers so they are
            // already valid during DONE.
            if (last) begin
               quotient  <= quo_fix;
               remainder <= rem_fix;
               div_done  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         div_req = 1'b0;
   logic         div_signed = 1'b0;
   logic         cancel = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         E_div_stall;
   logic         div_done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;

   int checks = 0;
   int errors = 0;

   div_iter #(.WIDTH(W)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .div_req     (div_req),
      .div_signed  (div_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .cancel      (cancel),
      .E_div_stall (E_div_stall),
      .div_done    (div_done),
      .quotient    (quotient),
      .remainder   (remainder)
   );

   always #5 clk = ~clk;

   // Issues one divide at the next falling edge (cycle T0) and runs until
   // div_done or a 40-cycle budget; lat is the cycle of div_done relative to
   // T0, stalls the number of cycles E_div_stall was high before it.
   task automatic do_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int stalls);
      @(negedge clk);
      div_signed = sgn;
      dividend   = a;
      divisor    = b;
      div_req    = 1'b1;
      lat        = 0;
      stalls     = 0;
      #1;
      while (div_done !== 1'b1 && lat < 40) begin
         if (E_div_stall === 1'b1) stalls++;
         @(negedge clk);
         #1;
         lat++;
         div_req = 1'b0;
      end
      div_req = 1'b0;
   endtask

   task automatic test_reset();
      div_req = 1'b1;
      #12;
      checks++;
      if (E_div_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", E_div_stall); end
      checks++;
      if (div_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", div_done); end
      checks++;
      if (quotient !== 32'h0 || remainder !== 32'h0) begin
         errors++; $display("FAIL reset_outputs: got q=%h r=%h expected 0/0", quotient, remainder);
      end
      div_req = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_divu_basic();
      int lat, stalls;
      do_div(1'b0, 32'd100, 32'd7, lat, stalls);
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d expected 33", lat); end
      checks++;
      if (stalls !== 33) begin errors++; $display("FAIL divu_stall_cycles: got %0d expected 33", stalls); end
      checks++;
      if (E_div_stall !== 1'b0) begin errors++; $display("FAIL divu_stall_at_done: got %b expected 0", E_div_stall); end
      checks++;
      if (quotient !== 32'd14 || remainder !== 32'd2) begin
         errors++; $display("FAIL divu_100_7: got q=%h r=%h expected %h/%h", quotient, remainder, 32'd14, 32'd2);
      end
      @(negedge clk);
      #1;
      checks++;
      if (div_done !== 1'b0) begin errors++; $display("FAIL divu_done_pulse_width: got %b expected 0", div_done); end
   endtask

   task automatic test_signed();
      int lat, stalls;
      do_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat, stalls);
      checks++;
      if (lat !== 33 || quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL div_m7_2: got lat=%0d q=%h r=%h expected 33 fffffffd/ffffffff", lat, quotient, remainder);
      end
      do_div(1'b1, 32'd7, 32'hFFFF_FFFE, lat, stalls);
      checks++;
      if (lat !== 33 || quotient !== 32'hFFFF_FFFD || remainder !== 32'd1) begin
         errors++; $display("FAIL div_7_m2: got lat=%0d q=%h r=%h expected 33 fffffffd/00000001", lat, quotient, remainder);
      end
      do_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, lat, stalls);
      checks++;
      if (quotient !== 32'd14 || remainder !== 32'hFFFF_FFFE) begin
         errors++; $display("FAIL div_m100_m7: got q=%h r=%h expected 0000000e/fffffffe", quotient, remainder);
      end
   endtask

   task automatic test_corners();
      int lat, stalls;
      do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, stalls);
      checks++;
      if (quotient !== 32'h8000_0000 || remainder !== 32'h0) begin
         errors++; $display("FAIL div_min_m1: got q=%h r=%h expected 80000000/00000000", quotient, remainder);
      end
      do_div(1'b0, 32'd5, 32'd0, lat, stalls);
      checks++;
      if (lat !== 33 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd5) begin
         errors++; $display("FAIL divu_5_0: got lat=%0d q=%h r=%h expected 33 ffffffff/00000005", lat, quotient, remainder);
      end
      do_div(1'b1, 32'hFFFF_FFF7, 32'd0, lat, stalls);
      checks++;
      if (quotient !== 32'hFFFF_FFFF || remainder !== 32'hFFFF_FFF7) begin
         errors++; $display("FAIL div_m9_0: got q=%h r=%h expected ffffffff/fffffff7", quotient, remainder);
      end
      do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, stalls);
      checks++;
      if (quotient !== 32'h0 || remainder !== 32'h8000_0000) begin
         errors++; $display("FAIL divu_big_small: got q=%h r=%h expected 00000000/80000000", quotient, remainder);
      end
      do_div(1'b0, 32'hFFFF_FFFF, 32'd1, lat, stalls);
      checks++;
      if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h0) begin
         errors++; $display("FAIL divu_max_1: got q=%h r=%h expected ffffffff/00000000", quotient, remainder);
      end
   endtask

   task automatic test_cancel();
      int lat, stalls;
      logic seen_done;
      @(negedge clk);
      div_signed = 1'b0;
      dividend   = 32'd1000;
      divisor    = 32'd3;
      div_req    = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         div_req = 1'b0;
      end
      cancel = 1'b1;
      #1;
      checks++;
      if (E_div_stall !== 1'b1) begin errors++; $display("FAIL cancel_busy_stall: got %b expected 1", E_div_stall); end
      @(negedge clk);
      cancel = 1'b0;
      #1;
      checks++;
      if (E_div_stall !== 1'b0) begin errors++; $display("FAIL cancel_stall_low: got %b expected 0", E_div_stall); end
      seen_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (div_done === 1'b1) seen_done = 1'b1;
      end
      checks++;
      if (seen_done !== 1'b0) begin errors++; $display("FAIL cancel_no_done: got %b expected 0", seen_done); end
      checks++;
      if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h0) begin
         errors++; $display("FAIL cancel_outputs_held: got q=%h r=%h expected ffffffff/00000000", quotient, remainder);
      end
      @(negedge clk);
      div_req = 1'b1;
      cancel  = 1'b1;
      #1;
      checks++;
      if (E_div_stall !== 1'b0) begin errors++; $display("FAIL cancel_priority_stall: got %b expected 0", E_div_stall); end
      @(negedge clk);
      div_req = 1'b0;
      cancel  = 1'b0;
      #1;
      checks++;
      if (E_div_stall !== 1'b0 || div_done !== 1'b0) begin
         errors++; $display("FAIL cancel_priority_idle: got stall=%b done=%b expected 0/0", E_div_stall, div_done);
      end
      do_div(1'b0, 32'd1000, 32'd3, lat, stalls);
      checks++;
      if (lat !== 33 || quotient !== 32'd333 || remainder !== 32'd1) begin
         errors++; $display("FAIL cancel_next_div: got lat=%0d q=%h r=%h expected 33 0000014d/00000001", lat, quotient, remainder);
      end
   endtask

   task automatic test_reset_mid();
      int lat, stalls;
      @(negedge clk);
      div_signed = 1'b0;
      dividend   = 32'd77;
      divisor    = 32'd5;
      div_req    = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         div_req = 1'b0;
      end
      resetn = 1'b0;
      #1;
      checks++;
      if (E_div_stall !== 1'b0 || div_done !== 1'b0 || quotient !== 32'h0 || remainder !== 32'h0) begin
         errors++; $display("FAIL reset_mid_busy: got stall=%b done=%b q=%h r=%h expected 0/0/0/0",
                            E_div_stall, div_done, quotient, remainder);
      end
      div_req = 1'b1;
      #1;
      checks++;
      if (E_div_stall !== 1'b0) begin errors++; $display("FAIL reset_req_ignored: got %b expected 0", E_div_stall); end
      @(negedge clk);
      div_req = 1'b0;
      resetn  = 1'b1;
      #1;
      checks++;
      if (E_div_stall !== 1'b0 || div_done !== 1'b0) begin
         errors++; $display("FAIL reset_release_idle: got stall=%b done=%b expected 0/0", E_div_stall, div_done);
      end
      do_div(1'b1, 32'hFFFF_FF9C, 32'd7, lat, stalls);
      checks++;
      if (lat !== 33 || quotient !== 32'hFFFF_FFF2 || remainder !== 32'hFFFF_FFFE) begin
         errors++; $display("FAIL reset_fresh_div: got lat=%0d q=%h r=%h expected 33 fffffff2/fffffffe", lat, quotient, remainder);
      end
   endtask

   task automatic test_back_to_back();
      int ndone, first, second;
      logic overlap;
      ndone   = 0;
      first   = -1;
      second  = -1;
      overlap = 1'b0;
      @(negedge clk);
      div_signed = 1'b0;
      dividend   = 32'd100;
      divisor    = 32'd7;
      div_req    = 1'b1;
      for (int c = 0; c < 80; c++) begin
         #1;
         if (div_done === 1'b1) begin
            ndone++;
            if (E_div_stall !== 1'b0) overlap = 1'b1;
            if (first < 0) first = c;
            else if (second < 0) second = c;
         end
         @(negedge clk);
      end
      div_req = 1'b0;
      repeat (40) @(negedge clk);
      checks++;
      if (ndone !== 2) begin errors++; $display("FAIL b2b_pulse_count: got %0d expected 2", ndone); end
      checks++;
      if (first !== 33 || second !== 67) begin
         errors++; $display("FAIL b2b_pulse_cycles: got %0d,%0d expected 33,67", first, second);
      end
      checks++;
      if (overlap !== 1'b0) begin errors++; $display("FAIL b2b_done_with_stall: got %b expected 0", overlap); end
      checks++;
      if (quotient !== 32'd14 || remainder !== 32'd2) begin
         errors++; $display("FAIL b2b_result: got q=%h r=%h expected 0000000e/00000002", quotient, remainder);
      end
   endtask

   initial begin
      test_reset();
      test_divu_basic();
      test_signed();
      test_corners();
      test_cancel();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
